// File: rtl/regfile_scoreboard.sv
// Register file with hard-wired r0, two combinational read ports and a pending-write scoreboard.
// Optional zero-cycle writeback-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] readRegister1,
   input  logic [ADDR_W-1:0] readRegister2,
   output logic [WIDTH-1:0]  readData1,
   output logic [WIDTH-1:0]  readData2,
   output logic              busy1,
   output logic              busy2,
   input  logic [ADDR_W-1:0] writeRegister,
   input  logic [WIDTH-1:0]  writeData,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] reserveRegister,
   input  logic              reserve,
   output logic              reserveGrant,
   output logic [ADDR_W:0]   pendingCount,
   output logic              error
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] pending_q, pending_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             error_q, error_d;
   logic             wr_en, clr_en;

   // Entry 0 is never written, so it stays at its reset value of zero.
   assign wr_en  = regWrite && (writeRegister != '0);
   assign clr_en = wr_en && pending_q[writeRegister];

   // A register may be re-reserved in the same cycle its current producer writes back.
   assign reserveGrant = reserve && (reserveRegister != '0) &&
                         (!pending_q[reserveRegister] ||
                          (wr_en && (writeRegister == reserveRegister)));

   assign pendingCount = count_q;
   assign error        = error_q;

   always_comb begin
      regs_d    = regs_q;
      pending_d = pending_q;
      count_d   = count_q;
      error_d   = error_q;

      if (wr_en) begin
         regs_d[writeRegister] = writeData;
         if (pending_q[writeRegister]) begin
            pending_d[writeRegister] = 1'b0;
         end else begin
            error_d = 1'b1;
         end
      end

      // Grant is applied after the clear so it wins on a shared address.
      if (reserveGrant) begin
         pending_d[reserveRegister] = 1'b1;
      end

      case ({reserveGrant, clr_en})
         2'b10: begin
            if (count_q == CNT_W'(DEPTH - 1)) begin
               error_d = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         2'b01: begin
            if (count_q == '0) begin
               error_d = 1'b1;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         pending_q <= '0;
         count_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pending_q <= pending_d;
         count_q   <= count_d;
         error_q   <= error_d;
      end
   end

   // Combinational read ports.
   always_comb begin
      readData1 = (readRegister1 == '0) ? '0 : regs_q[readRegister1];
      readData2 = (readRegister2 == '0) ? '0 : regs_q[readRegister2];
      busy1     = (readRegister1 != '0) && pending_q[readRegister1];
      busy2     = (readRegister2 != '0) && pending_q[readRegister2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (writeRegister == readRegister1)) begin
         readData1 = writeData;
         busy1     = 1'b0;
      end
      if (wr_en && (writeRegister == readRegister2)) begin
         readData2 = writeData;
         busy2     = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: driver pushes model expectations, negedge monitor compares.
module tb_regfile_scoreboard;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] readRegister1, readRegister2, writeRegister, reserveRegister;
   logic [WIDTH-1:0]  readData1, readData2, writeData;
   logic              busy1, busy2, regWrite, reserve, reserveGrant, error;
   logic [ADDR_W:0]   pendingCount;

   regfile_scoreboard #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .readRegister1  (readRegister1),
      .readRegister2  (readRegister2),
      .readData1      (readData1),
      .readData2      (readData2),
      .busy1          (busy1),
      .busy2          (busy2),
      .writeRegister  (writeRegister),
      .writeData      (writeData),
      .regWrite       (regWrite),
      .reserveRegister(reserveRegister),
      .reserve        (reserve),
      .reserveGrant   (reserveGrant),
      .pendingCount   (pendingCount),
      .error          (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int        tag;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic      b1;
      logic      b2;
      logic      grant;
      int        cnt;
      logic      err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   tag_ctr  = 0;

   // Reference state: plain arrays, count derived as number of reserved registers.
   logic [31:0] m_mem [DEPTH];
   bit          m_pend [DEPTH];
   bit          m_err;

   function automatic int m_count();
      int c = 0;
      for (int i = 1; i < DEPTH; i++) if (m_pend[i]) c++;
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = 0;
         m_pend[i] = 0;
      end
      m_err = 0;
   endtask

   task automatic chk(input string nm, input int tag, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s tag=%0d actual=0x%0h required=0x%0h", nm, tag, act, req);
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("readData1",    e.tag, 64'(readData1),    64'(e.rd1));
         chk("readData2",    e.tag, 64'(readData2),    64'(e.rd2));
         chk("busy1",        e.tag, 64'(busy1),        64'(e.b1));
         chk("busy2",        e.tag, 64'(busy2),        64'(e.b2));
         chk("reserveGrant", e.tag, 64'(reserveGrant), 64'(e.grant));
         chk("pendingCount", e.tag, 64'(pendingCount), 64'(e.cnt));
         chk("error",        e.tag, 64'(error),        64'(e.err));
      end
   end

   function automatic logic [31:0] m_read(input int a);
      return (a == 0) ? 32'd0 : m_mem[a];
   endfunction

   // Drive one cycle of stimulus, predict outputs, then advance the model across the edge.
   task automatic cycle(input int ra1, input int ra2, input int wa, input logic [31:0] wd,
                        input bit we, input int rr, input bit rsv);
      exp_t e;
      bit   wen, grant;
      @(posedge clk);
      #1;
      rst_n           = 1'b1;
      readRegister1   = ADDR_W'(ra1);
      readRegister2   = ADDR_W'(ra2);
      writeRegister   = ADDR_W'(wa);
      writeData       = wd;
      regWrite        = we;
      reserveRegister = ADDR_W'(rr);
      reserve         = rsv;
      wen   = we && (wa != 0);
      grant = rsv && (rr != 0) && (!m_pend[rr] || (wen && wa == rr));
      e.tag   = tag_ctr++;
      e.rd1   = m_read(ra1);
      e.rd2   = m_read(ra2);
      e.b1    = (ra1 != 0) && m_pend[ra1];
      e.b2    = (ra2 != 0) && m_pend[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wen && wa == ra1) begin e.rd1 = wd; e.b1 = 0; end
      if (wen && wa == ra2) begin e.rd2 = wd; e.b2 = 0; end
`endif
      e.grant = grant;
      e.cnt   = m_count();
      e.err   = m_err;
      exp_q.push_back(e);
      if (wen) begin
         m_mem[wa] = wd;
         if (!m_pend[wa]) m_err = 1;
         m_pend[wa] = 0;
      end
      if (grant) m_pend[rr] = 1;
   endtask

   task automatic apply_reset();
      exp_t e;
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      regWrite = 1'b0;
      reserve  = 1'b0;
      model_reset();
      e.tag = tag_ctr++;
      e.rd1 = 0; e.rd2 = 0; e.b1 = 0; e.b2 = 0; e.grant = 0; e.cnt = 0; e.err = 0;
      exp_q.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      readRegister1 = '0; readRegister2 = '0; writeRegister = '0; reserveRegister = '0;
      writeData = '0; regWrite = 1'b0; reserve = 1'b0;
      model_reset();
      apply_reset();

      // r2: reserve, write 42, re-reserve, write 15
      cycle(2, 2, 0, 0,  0, 2, 1);
      cycle(2, 2, 2, 42, 1, 0, 0);
      cycle(2, 2, 0, 0,  0, 2, 1);
      cycle(2, 2, 2, 15, 1, 0, 0);
      cycle(2, 2, 0, 0,  0, 0, 0);
      // r3: reserve, duplicate reserve refused, write 19
      cycle(3, 2, 0, 0,  0, 3, 1);
      cycle(3, 2, 0, 0,  0, 3, 1);
      cycle(3, 2, 3, 19, 1, 0, 0);
      cycle(3, 2, 0, 0,  0, 0, 0);
      // r0 write and reserve ignored
      cycle(0, 0, 0, 15, 1, 0, 1);
      cycle(0, 0, 0, 0,  0, 0, 0);
      // r5 writeback and re-reserve in the same cycle
      cycle(5, 5, 0, 0,  0, 5, 1);
      cycle(5, 5, 5, 77, 1, 5, 1);
      cycle(5, 5, 0, 0,  0, 0, 0);
      cycle(5, 5, 5, 78, 1, 0, 0);
      // r4 writeback observed on port 2 before and after the edge
      cycle(0, 4, 0, 0,      0, 4, 1);
      cycle(0, 4, 4, 32'hA5, 1, 0, 0);
      cycle(0, 4, 0, 0,      0, 0, 0);
      // unreserved write to r9 sets sticky error; reserve r6 then reset loses it
      cycle(9, 9, 9, 7, 1, 6, 1);
      cycle(9, 6, 0, 0, 0, 0, 0);
      cycle(9, 6, 0, 0, 0, 0, 0);
      apply_reset();
      cycle(9, 6, 0, 0, 0, 0, 0);
      cycle(9, 6, 6, 3, 1, 0, 0);
      cycle(9, 6, 0, 0, 0, 0, 0);
      apply_reset();

      // Randomized traffic, mostly on a small address window to force collisions
      for (int n = 0; n < 800; n++) begin
         int wa, rr, ra1, ra2;
         bit we;
         if (n % 150 == 149) begin
            apply_reset();
         end else begin
            ra1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
            rr  = int'($urandom_range(0, 7));
            wa  = int'($urandom_range(0, 7));
            // favour writebacks to reserved registers so error is not always set
            if ($urandom_range(0, 3) != 0) begin
               for (int k = 0; k < 8; k++) begin
                  int c = int'($urandom_range(1, 7));
                  if (m_pend[c]) begin wa = c; break; end
               end
            end
            we = ($urandom_range(0, 9) < 4);
            if (we && wa != 0 && !m_pend[wa] && $urandom_range(0, 3) != 0) we = 0;
            cycle(ra1, ra2, wa, $urandom, we, rr, ($urandom_range(0, 9) < 4));
         end
      end

      @(posedge clk);
      #1;
      regWrite = 1'b0;
      reserve  = 1'b0;
      @(negedge clk);
      #1;
      chk("queue_drained", -1, 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
